// File: rtl/keypad_entry.sv
// Keypad front end for the lock: conditions the digit and submit buttons, gathers up to
// four digits into the in_test slots and issues the strobes that code_checker consumes.
module keypad_entry #(
  parameter int DIGIT_W         = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] key_value,
  input  logic               key_press,
  input  logic               submit_btn,
  input  logic               input_reset,
  output logic [DIGIT_W-1:0] in_test0,
  output logic [DIGIT_W-1:0] in_test1,
  output logic [DIGIT_W-1:0] in_test2,
  output logic [DIGIT_W-1:0] in_test3,
  output logic [2:0]         num_inputs,
  output logic               input_value,
  output logic               compare,
  output logic               overflow,
  output logic               timeout
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

  // Bit 0 is the digit button, bit 1 the submit button.
  logic [1:0]       raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       event_q, event_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  state_t             state_q, state_d;
  logic [DIGIT_W-1:0] slot_q [4];
  logic [DIGIT_W-1:0] slot_d [4];
  logic [2:0]         num_q, num_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               inputValue_q, inputValue_d;
  logic               compare_q, compare_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;

  logic keyEvt, subEvt;

  assign raw    = {submit_btn, key_press};
  assign keyEvt = event_q[0];
  assign subEvt = event_q[1];

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples;
  // only the accepted 0->1 change raises a one-cycle event.
  always_comb begin
    stable_d = stable_q;
    event_d  = '0;
    cnt_d    = cnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] == stable_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_LAST) begin
        cnt_d[b]    = '0;
        stable_d[b] = sync2_q[b];
        event_d[b]  = sync2_q[b];
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      event_q  <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      event_q  <= event_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry FSM; input_reset beats submit, submit beats timer expiry, expiry beats a key.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    num_d        = num_q;
    timer_d      = timer_q;
    inputValue_d = 1'b0;
    compare_d    = 1'b0;
    overflow_d   = 1'b0;
    timeout_d    = 1'b0;
    if (input_reset) begin
      state_d = IDLE;
      slot_d  = '{default: '0};
      num_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (keyEvt && !subEvt) begin
            slot_d[0]    = key_value;
            num_d        = 3'd1;
            timer_d      = '0;
            inputValue_d = 1'b1;
            state_d      = ENTRY;
          end
        end
        ENTRY: begin
          if (subEvt) begin
            compare_d = 1'b1;
            timer_d   = '0;
            state_d   = DONE;
          end else if (timer_q == TMR_LAST) begin
            slot_d    = '{default: '0};
            num_d     = '0;
            timer_d   = '0;
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else if (keyEvt) begin
            timer_d = '0;
            if (num_q == 3'd4) begin
              overflow_d = 1'b1;
            end else begin
              slot_d[num_q[1:0]] = key_value;
              num_d              = num_q + 3'd1;
              inputValue_d       = 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      slot_q       <= '{default: '0};
      num_q        <= '0;
      timer_q      <= '0;
      inputValue_q <= 1'b0;
      compare_q    <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      num_q        <= num_d;
      timer_q      <= timer_d;
      inputValue_q <= inputValue_d;
      compare_q    <= compare_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
    end
  end

  assign in_test0    = slot_q[0];
  assign in_test1    = slot_q[1];
  assign in_test2    = slot_q[2];
  assign in_test3    = slot_q[3];
  assign num_inputs  = num_q;
  assign input_value = inputValue_q;
  assign compare     = compare_q;
  assign overflow    = overflow_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Upstream stage of code_checker in the lock datapath.
- Takes raw keypad digit and submit buttons, then synchronises and debounces them.
- Assembles up to four entered digits into the in_test0..in_test3 operand slots, and issues the input_value strobe and the compare strobe that code_checker consumes.
- Reports the digit count to the Controller as num_inputs, and discards a stale partial entry after an inactivity timeout.

Parameters:
- DIGIT_W, 4, width of one keypad digit and of each in_test slot.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a button level change is accepted (min 1).
- TIMEOUT_CYCLES, 1000, idle cycles in ENTRY before the partial entry is discarded (min 2).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- key_value  input  DIGIT_W  digit code on keypad; sampled in the cycle a press is accepted.
- key_press  input  1  raw asynchronous digit-button level, high = pressed.
- submit_btn  input  1  raw asynchronous submit-button level, high = pressed.
- input_reset  input  1  synchronous clear from Controller; same signal that resets code_checker input register.
- in_test0..in_test3  output  DIGIT_W each  captured digits; in_test0 = first digit entered.
- num_inputs  output  3  count of captured digits, 0..4.
- input_value  output  1  one-cycle strobe; a new digit was written to in_test slots.
- compare  output  1  one-cycle strobe; entry complete, code_checker must compare.
- overflow  output  1  one-cycle strobe; a digit was pressed while 4 were already held.
- timeout  output  1  one-cycle strobe; the partial entry was discarded by inactivity.

Behaviour:
- Reset (async): all in_test slots = 0; num_inputs = 0; all strobes = 0; state = IDLE; synchronisers, debouncers and timers = 0.
- Input conditioning:
  - Each raw button passes through a 2-flop synchroniser, then a debouncer.
  - The debouncer updates its stable level only after DEBOUNCE_CYCLES consecutive equal synchronised samples differing from the current stable level.
  - A 0->1 transition of the stable level is one accepted event, a single-cycle internal pulse.
  - Minimum latency raw rise -> accepted event = 2 + DEBOUNCE_CYCLES cycles.
- Strobes are registered: input_value, compare, overflow and timeout assert on the cycle after the accepted event / timer expiry, for exactly 1 cycle.
- FSM states: IDLE, ENTRY, DONE.
  - IDLE, key event: in_test0 <= key_value, num_inputs <= 1, input_value pulse, -> ENTRY.
  - IDLE, submit event: ignored (empty entry never compared).
  - ENTRY, key event, num_inputs < 4: slot[num_inputs] <= key_value, num_inputs += 1, input_value pulse.
  - ENTRY, key event, num_inputs == 4: slots unchanged, overflow pulse.
  - ENTRY, submit event: compare pulse, -> DONE; slots and num_inputs held stable while compare is high and afterwards.
  - ENTRY, idle timer reaches TIMEOUT_CYCLES: slots = 0, num_inputs = 0, timeout pulse, -> IDLE.
  - DONE: key and submit events ignored; leave only via input_reset or reset.
- Idle timer:
  - Runs only in ENTRY; cleared on entering ENTRY and on every accepted key event, including overflow.
  - Expiry fires on the cycle the count equals TIMEOUT_CYCLES-1; no wrap.
- input_reset (any state): slots = 0, num_inputs = 0, state = IDLE, timer = 0, pending strobes suppressed.
  - Debouncer stable levels are kept, so a held button does not re-fire.
- Priority in one cycle: reset > input_reset > submit event > timer expiry > key event.
  - A key event coincident with a submit event is dropped; the entry compares with the digits already held.
- Reset mid-debounce or mid-entry: everything returns to reset values immediately; no strobe is emitted afterwards for that press.
- Held button: exactly one event per press; auto-repeat is not generated.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no event.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64.
- Press keys 1,2,3,4 (each held 10 cycles, 10-cycle gaps) -> four input_value pulses; in_test0..3 = 1,2,3,4; num_inputs = 4; each pulse 7 cycles after the raw rise.
- With 4 digits held, press 9 -> overflow pulse, no input_value, in_test3 stays 4; then submit -> one compare pulse, state DONE, slots unchanged 20 cycles later.
- In DONE, press 5 and submit again -> no strobes; assert input_reset 1 cycle -> num_inputs = 0, slots = 0; press 5 -> in_test0 = 5, num_inputs = 1.
- Press 7, then idle 64 cycles -> timeout pulse, num_inputs = 0, in_test0 = 0; submit in IDLE -> no compare.
- Key bounce: 3-cycle high glitches on key_press -> no event; submit and key both stable-rising the same cycle with 2 digits held -> compare only, num_inputs stays 2.
- Assert reset asynchronously between clock edges while 3 digits are held and a key is mid-debounce -> outputs are 0 immediately (before the next edge); no input_value afterwards.
